inst_boot_loader: RTL and testbench

//   Upstream of the instruction fetcher. Receives a byte stream over a valid/ready handshake.

---
 rtl/inst_boot_loader_pkg.sv | 29 ++
 rtl/inst_boot_loader_byte_packer.sv | 38 +++
 rtl/inst_boot_loader.sv | 150 +++++++++++++++
 tb/tb_inst_boot_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_boot_loader_pkg
// Brief    : Shared types, state encoding and helpers for the boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package inst_boot_loader_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [31:0] addr_t;

    typedef logic [2:0] boot_state_t;

    localparam boot_state_t c_ST_IDLE    = 3'd0;
    localparam boot_state_t c_ST_HEADER  = 3'd1;
    localparam boot_state_t c_ST_PAYLOAD = 3'd2;
    localparam boot_state_t c_ST_WRITE   = 3'd3;
    localparam boot_state_t c_ST_DONE    = 3'd4;
    localparam boot_state_t c_ST_ERROR   = 3'd5;

    localparam int c_BOOT_WORD_BYTES = 4;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic addr_t word_addr(input addr_t base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_boot_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : inst_boot_loader_byte_packer
// Brief    : Big-endian byte-to-word assembler shared by header and payload.
// Revision : 1.0 - initial release
// ============================================================================
module inst_boot_loader_byte_packer
    import inst_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        full
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (shift_en) begin
            r_shift <= {r_shift[15:0], data};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    // Word as it stands including the byte offered this cycle, so the
    // consumer can act on the 4th byte at the edge that accepts it.
    assign word = {r_shift, data};
    assign full = (r_cnt == 2'(c_BOOT_WORD_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/inst_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_boot_loader
// Brief    : Streams a length-prefixed big-endian image into instruction memory
//            and holds the CPU in reset until the load completes.
// Revision : 1.0 - initial release
// ============================================================================
module inst_boot_loader
    import inst_boot_loader_pkg::*;
#(
    parameter addr_t BASE_ADDR      = 32'h0,
    parameter int    MAX_WORDS      = 1024,
    parameter int    TIMEOUT_CYCLES = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] load_inst,
    output logic [31:0] load_addr,
    output logic        loading_inst,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int c_IDX_W = $clog2(MAX_WORDS + 1);
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST =
        (TIMEOUT_CYCLES > 0) ? c_TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    boot_state_t        r_state;
    boot_state_t        w_state_next;
    logic [31:0]        r_count;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_TMR_W-1:0] r_timer;
    inst_t              r_load_inst;
    addr_t              r_load_addr;

    logic        w_accept;
    logic        w_word_done;
    logic        w_start;
    logic        w_timeout;
    logic        w_last_word;
    logic        w_pk_clear;
    logic [31:0] w_word;
    logic        w_full;

    assign w_accept    = byte_valid && byte_ready;
    assign w_word_done = w_accept && w_full;
    assign w_start     = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_ERROR));
    assign w_last_word = ((32'(r_idx) + 32'd1) == r_count);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && byte_ready && !w_accept
                         && (r_timer == c_TMR_LAST);
    assign w_pk_clear  = !((r_state == c_ST_HEADER) || (r_state == c_ST_PAYLOAD)
                           || (r_state == c_ST_WRITE));

    inst_boot_loader_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_pk_clear),
        .shift_en (w_accept),
        .data     (byte_data),
        .word     (w_word),
        .full     (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (start) w_state_next = c_ST_HEADER;
            c_ST_HEADER: begin
                if (w_word_done) begin
                    if (w_word == 32'd0)                 w_state_next = c_ST_DONE;
                    else if (w_word > 32'(MAX_WORDS))    w_state_next = c_ST_ERROR;
                    else                                 w_state_next = c_ST_PAYLOAD;
                end else if (w_timeout) begin
                    w_state_next = c_ST_ERROR;
                end
            end
            c_ST_PAYLOAD: begin
                if (w_word_done)    w_state_next = c_ST_WRITE;
                else if (w_timeout) w_state_next = c_ST_ERROR;
            end
            c_ST_WRITE:   w_state_next = w_last_word ? c_ST_DONE : c_ST_PAYLOAD;
            c_ST_DONE:    w_state_next = c_ST_DONE;
            c_ST_ERROR:   if (start) w_state_next = c_ST_HEADER;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready   = 1'b0;
        loading_inst = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            c_ST_HEADER,
            c_ST_PAYLOAD: byte_ready   = 1'b1;
            c_ST_WRITE:   loading_inst = 1'b1;
            c_ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            c_ST_ERROR:   error        = 1'b1;
            default:      ;
        endcase
    end

    // The write port values are captured with the 4th byte and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_load_inst <= '0;
            r_load_addr <= '0;
        end else begin
            if (w_start) begin
                r_count <= '0;
                r_idx   <= '0;
            end
            if ((r_state == c_ST_HEADER) && w_word_done)
                r_count <= w_word;
            if ((r_state == c_ST_PAYLOAD) && w_word_done) begin
                r_load_inst <= w_word;
                r_load_addr <= word_addr(BASE_ADDR, 32'(r_idx));
            end
            if (r_state == c_ST_WRITE)
                r_idx <= r_idx + c_IDX_W'(1);
            if (w_accept || (w_state_next != r_state))
                r_timer <= '0;
            else if (byte_ready)
                r_timer <= r_timer + c_TMR_W'(1);
        end
    end

    assign load_inst = r_load_inst;
    assign load_addr = r_load_addr;

endmodule
`default_nettype wire

// File: tb/tb_inst_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_boot_loader
// Brief    : Directed + randomised-gap bench with an expected-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_boot_loader;

    localparam logic [31:0] c_BASE = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready, loading_inst, cpu_hold, done, error;
    logic [31:0] load_inst, load_addr;

    int   total = 0;
    int   bad   = 0;
    int   n_strobes = 0;
    int   mark;
    logic prev_strobe = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    inst_boot_loader #(
        .BASE_ADDR      (c_BASE),
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .load_inst    (load_inst),
        .load_addr    (load_addr),
        .loading_inst (loading_inst),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (loading_inst === 1'b1) begin
            exp_t e;
            n_strobes++;
            check("no_back_to_back", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_addr", load_addr, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("strobe_addr", load_addr, e.addr);
                check("strobe_data", load_inst, e.data);
            end
        end
        prev_strobe = (loading_inst === 1'b1);
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic gap(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 3; k >= 0; k--) begin
            if (max_gap > 0) gap($urandom_range(0, max_gap));
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;

        // Reset state
        do_reset();
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_loading", {31'd0, loading_inst}, 32'd0);
        check("rst_load_inst", load_inst, 32'd0);

        // Gap-free two-word image
        pulse_start();
        check("hdr_ready", {31'd0, byte_ready}, 32'd1);
        mark = n_strobes;
        exp_q.push_back('{c_BASE + 32'd0, 32'h2008_0005});
        exp_q.push_back('{c_BASE + 32'd4, 32'h0109_5020});
        send_word(32'd2, 0);
        send_word(32'h2008_0005, 0);
        send_word(32'h0109_5020, 0);
        gap(0);
        wait_done(10);
        check("two_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("two_strobes", n_strobes - mark, 32'd2);
        check("two_held_inst", load_inst, 32'h0109_5020);
        pulse_start();
        check("done_ignores_start", {31'd0, done}, 32'd1);

        // Empty header
        do_reset();
        pulse_start();
        mark = n_strobes;
        send_word(32'd0, 0);
        gap(0);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("empty_strobes", n_strobes - mark, 32'd0);

        // Oversized header (MAX_WORDS+1)
        do_reset();
        pulse_start();
        mark = n_strobes;
        send_word(32'd1025, 0);
        gap(2);
        check("over_error", {31'd0, error}, 32'd1);
        check("over_ready", {31'd0, byte_ready}, 32'd0);
        check("over_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("over_strobes", n_strobes - mark, 32'd0);

        // Stall until timeout, then recover with a fresh image
        do_reset();
        pulse_start();
        mark = n_strobes;
        send_word(32'd1, 0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        gap(15);
        check("stall_15_no_error", {31'd0, error}, 32'd0);
        gap(1);
        check("stall_16_error", {31'd0, error}, 32'd1);
        check("stall_ready", {31'd0, byte_ready}, 32'd0);
        pulse_start();
        check("restart_clears_error", {31'd0, error}, 32'd0);
        exp_q.push_back('{c_BASE, 32'h3C01_1234});
        send_word(32'd1, 0);
        send_word(32'h3C01_1234, 0);
        gap(0);
        wait_done(10);
        check("recover_strobes", n_strobes - mark, 32'd1);

        // Reset after the 6th payload byte
        do_reset();
        pulse_start();
        mark = n_strobes;
        exp_q.push_back('{c_BASE, 32'hDEAD_BEEF});
        send_word(32'd2, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        check("midrst_first_seen", n_strobes - mark, 32'd1);
        do_reset();
        check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_idle_ready", {31'd0, byte_ready}, 32'd0);
        check("midrst_no_more", n_strobes - mark, 32'd1);
        gap(0);

        // 64-word image with random byte gaps
        do_reset();
        pulse_start();
        mark = n_strobes;
        send_word(32'd64, 3);
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            exp_q.push_back('{c_BASE + 32'(i * 4), w});
            send_word(w, 3);
        end
        gap(0);
        wait_done(20);
        check("rand_strobes", n_strobes - mark, 32'd64);
        check("rand_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
